// File: rtl/uart_bridge_pkg.sv
// rtl/uart_bridge_pkg.sv - shared types and width helpers for the UART/AXI-stream bridge
package uart_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } tx_state_e;

    // Width needed to hold an occupancy count of 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width: one extra wrap bit so full and empty are distinguishable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axi_stream_if.sv
// rtl/axi_stream_if.sv - minimal AXI-stream style handshake bundle
interface axi_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/UART_wrapper.sv
// rtl/UART_wrapper.sv - serial UART core: LSB-first 8N1-style TX and RX with optional even parity
module UART_wrapper #(
    parameter int DATA_WIDTH  = 8,
    parameter int CLK_BITS    = 8,
    parameter int PARITY_BITS = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CLK_BITS-1:0]   clk_per_bit,
    input  logic                  tx_en,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic                  uart_tx,
    input  logic                  uart_rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_done,
    output logic                  RX_parityError
);
    localparam int TX_BITS = 1 + DATA_WIDTH + PARITY_BITS + STOP_BITS;
    localparam int TW      = $clog2(TX_BITS + 1);
    localparam int SW      = DATA_WIDTH + PARITY_BITS;
    localparam int RX_BITS = SW + 2;
    localparam int RW      = $clog2(RX_BITS + 1);

    logic [TX_BITS-1:0]  tx_frame;
    logic [TX_BITS-1:0]  tx_shift;
    logic [CLK_BITS-1:0] tx_cnt;
    logic [TW-1:0]       tx_left;
    logic                tx_bit_end;

    logic                rx_meta;
    logic                rx_sync;
    logic                rx_active;
    logic [CLK_BITS-1:0] rx_cnt;
    logic [RW-1:0]       rx_idx;
    logic [SW-1:0]       rx_shift;
    logic [SW-1:0]       rx_shift_next;
    logic                rx_mid;
    logic                rx_bit_end;

    // A divider of 0 behaves like 1: every clock ends a bit.
    assign tx_bit_end    = ({1'b0, tx_cnt} + (CLK_BITS+1)'(1)) >= {1'b0, clk_per_bit};
    assign rx_bit_end    = ({1'b0, rx_cnt} + (CLK_BITS+1)'(1)) >= {1'b0, clk_per_bit};
    assign rx_mid        = (rx_cnt == (clk_per_bit >> 1));
    assign rx_shift_next = {rx_sync, rx_shift[SW-1:1]};
    assign uart_tx       = tx_busy ? tx_shift[0] : 1'b1;

    // Whole TX frame, bit 0 first on the wire: start, data, optional parity, stop bits.
    always_comb begin
        tx_frame = '1;
        tx_frame[0] = 1'b0;
        tx_frame[DATA_WIDTH:1] = tx_data;
        if (PARITY_BITS != 0) tx_frame[DATA_WIDTH+1] = ^tx_data;
    end

    // TX shifter: one frame bit per clk_per_bit clocks, done pulses as busy drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            tx_shift <= '1;
            tx_cnt   <= '0;
            tx_left  <= '0;
        end else begin
            tx_done <= 1'b0;
            if (!tx_busy) begin
                if (tx_en) begin
                    tx_busy  <= 1'b1;
                    tx_shift <= tx_frame;
                    tx_cnt   <= '0;
                    tx_left  <= TW'(TX_BITS);
                end
            end else if (tx_bit_end) begin
                tx_cnt   <= '0;
                tx_shift <= {1'b1, tx_shift[TX_BITS-1:1]};
                tx_left  <= tx_left - TW'(1);
                if (tx_left == TW'(1)) begin
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
                end
            end else begin
                tx_cnt <= tx_cnt + CLK_BITS'(1);
            end
        end
    end

    // Two-flop synchroniser on the RX pin, idling high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    // RX sampler: mid-bit sampling, false starts rejected, done raised mid stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_active      <= 1'b0;
            rx_cnt         <= '0;
            rx_idx         <= '0;
            rx_shift       <= '0;
            rx_data        <= '0;
            rx_done        <= 1'b0;
            RX_parityError <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            if (!rx_active) begin
                if (!rx_sync) begin
                    rx_active <= 1'b1;
                    rx_cnt    <= '0;
                    rx_idx    <= '0;
                end
            end else begin
                rx_cnt <= rx_bit_end ? '0 : rx_cnt + CLK_BITS'(1);
                if (rx_mid) begin
                    if (rx_idx == '0) begin
                        if (rx_sync) rx_active <= 1'b0;
                        else         rx_idx    <= rx_idx + RW'(1);
                    end else if (rx_idx <= RW'(SW)) begin
                        rx_shift <= rx_shift_next;
                        rx_idx   <= rx_idx + RW'(1);
                    end else begin
                        rx_active      <= 1'b0;
                        rx_done        <= 1'b1;
                        rx_data        <= rx_shift[DATA_WIDTH-1:0];
                        RX_parityError <= (PARITY_BITS != 0) && (^rx_shift);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy level
module sync_fifo
    import uart_bridge_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            push,
    input  logic [WIDTH-1:0]                wdata,
    input  logic                            pop,
    output logic [WIDTH-1:0]                rdata,
    output logic                            full,
    output logic                            empty,
    output logic [level_width(DEPTH)-1:0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    diff;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from the registered pointers, so a same-cycle pop never
    // makes room for a push into a full FIFO.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign diff    = wptr - rptr;
    assign level   = LW'(diff);
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

    // Pointer advance; reset empties the FIFO immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
        end
    end

    // Storage write; contents need no reset because rdata is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_axis_fifo_bridge.sv
// rtl/uart_axis_fifo_bridge.sv - FIFO-buffered bridge between AXI-stream ports and a UART core
module uart_axis_fifo_bridge
    import uart_bridge_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int CLK_BITS    = 8,
    parameter int TX_DEPTH    = 16,
    parameter int RX_DEPTH    = 16,
    parameter int PARITY_BITS = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [CLK_BITS-1:0]               clk_per_bit,
    axi_stream_if.slave                       uart_in,
    axi_stream_if.master                      uart_out,
    output logic                              uart_tx,
    input  logic                              uart_rx,
    input  logic                              clear_status,
    output logic                              rx_overrun,
    output logic                              rx_parity_err,
    output logic [level_width(TX_DEPTH)-1:0]  tx_level,
    output logic [level_width(RX_DEPTH)-1:0]  rx_level
);
    tx_state_e             state;
    logic                  tx_en;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_busy;
    logic                  tx_done;
    logic                  tx_full;
    logic                  tx_empty;
    logic                  tx_pop;
    logic [DATA_WIDTH-1:0] tx_head;

    logic                  rx_done;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_perr_raw;
    logic                  rx_full;
    logic                  rx_empty;
    logic                  rx_push;
    logic                  parity_bad;
    logic                  overrun_evt;

    assign uart_in.tready  = !tx_full;
    assign tx_pop          = (state == START);
    assign uart_out.tvalid = !rx_empty;

    // Bytes with bad parity are dropped before the full check; only good bytes can overrun.
    assign parity_bad  = (PARITY_BITS != 0) && rx_perr_raw;
    assign rx_push     = rx_done && !parity_bad && !rx_full;
    assign overrun_evt = rx_done && !parity_bad && rx_full;

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (uart_in.tvalid),
        .wdata (uart_in.tdata),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .wdata (rx_data),
        .pop   (uart_out.tvalid && uart_out.tready),
        .rdata (uart_out.tdata),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

    UART_wrapper #(
        .DATA_WIDTH  (DATA_WIDTH),
        .CLK_BITS    (CLK_BITS),
        .PARITY_BITS (PARITY_BITS),
        .STOP_BITS   (STOP_BITS)
    ) u_core (
        .clk            (clk),
        .rst_n          (rst_n),
        .clk_per_bit    (clk_per_bit),
        .tx_en          (tx_en),
        .tx_data        (tx_data),
        .tx_busy        (tx_busy),
        .tx_done        (tx_done),
        .uart_tx        (uart_tx),
        .uart_rx        (uart_rx),
        .rx_data        (rx_data),
        .rx_done        (rx_done),
        .RX_parityError (rx_perr_raw)
    );

    // TX drain FSM: one-cycle tx_en in START with the FIFO head, popped in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx_en   <= 1'b0;
            tx_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx_en <= 1'b0;
                    if (!tx_empty && !tx_busy) begin
                        state   <= START;
                        tx_en   <= 1'b1;
                        tx_data <= tx_head;
                    end
                end
                START: begin
                    tx_en <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    tx_en <= 1'b0;
                    if (tx_done) state <= IDLE;
                end
                default: begin
                    tx_en <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a new event in the same cycle as clear_status wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_overrun    <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            rx_overrun    <= (rx_overrun && !clear_status) || overrun_evt;
            rx_parity_err <= (rx_parity_err && !clear_status) || (rx_done && parity_bad);
        end
    end

endmodule

// File: tb/tb_uart_axis_fifo_bridge.sv
// tb/tb_uart_axis_fifo_bridge.sv - directed self-checking bench for uart_axis_fifo_bridge
module tb_uart_axis_fifo_bridge;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] clk_per_bit = 8'd4;
    logic       a_rx = 1'b1;
    logic       b_rx = 1'b1;
    logic       a_clr = 1'b0;
    logic       b_clr = 1'b0;
    logic       a_tx, b_tx;
    logic       a_ovr, a_perr, b_ovr, b_perr;
    logic [4:0] a_txl, a_rxl, b_txl, b_rxl;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    axi_stream_if #(.DATA_WIDTH(8)) a_in ();
    axi_stream_if #(.DATA_WIDTH(8)) a_out ();
    axi_stream_if #(.DATA_WIDTH(8)) b_in ();
    axi_stream_if #(.DATA_WIDTH(8)) b_out ();

    uart_axis_fifo_bridge dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .clk_per_bit   (clk_per_bit),
        .uart_in       (a_in),
        .uart_out      (a_out),
        .uart_tx       (a_tx),
        .uart_rx       (a_rx),
        .clear_status  (a_clr),
        .rx_overrun    (a_ovr),
        .rx_parity_err (a_perr),
        .tx_level      (a_txl),
        .rx_level      (a_rxl)
    );

    uart_axis_fifo_bridge #(.PARITY_BITS(1)) dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .clk_per_bit   (clk_per_bit),
        .uart_in       (b_in),
        .uart_out      (b_out),
        .uart_tx       (b_tx),
        .uart_rx       (b_rx),
        .clear_status  (b_clr),
        .rx_overrun    (b_ovr),
        .rx_parity_err (b_perr),
        .tx_level      (b_txl),
        .rx_level      (b_rxl)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input bit which, input logic v);
        if (which) b_rx = v;
        else       a_rx = v;
    endtask

    // Serialise one byte LSB-first at 4 clocks per bit, 1.5 stop bits.
    task automatic send_serial(input bit which, input logic [7:0] d, input bit with_par, input logic par);
        set_rx(which, 1'b0);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_rx(which, d[i]);
            repeat (4) @(negedge clk);
        end
        if (with_par) begin
            set_rx(which, par);
            repeat (4) @(negedge clk);
        end
        set_rx(which, 1'b1);
        repeat (6) @(negedge clk);
    endtask

    // Capture one frame from DUT A's TX pin, sampling at bit centres.
    task automatic capture(output logic [7:0] d, output int start_cyc);
        int budget;
        budget = 0;
        d = 8'h00;
        start_cyc = -1000;
        while (a_tx !== 1'b0 && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (a_tx !== 1'b0) begin
            check("tx_frame_start_seen", 32'(a_tx), 32'(0));
            return;
        end
        start_cyc = cyc;
        repeat (2) @(negedge clk);
        check("tx_start_bit", 32'(a_tx), 32'(0));
        for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge clk);
            d[i] = a_tx;
        end
        repeat (4) @(negedge clk);
        check("tx_stop_bit", 32'(a_tx), 32'(1));
    endtask

    task automatic push_byte(input logic [7:0] d);
        int budget;
        budget = 0;
        a_in.tdata  = d;
        a_in.tvalid = 1'b1;
        while (!a_in.tready && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        if (!a_in.tready) check("tx_push_ready", 32'(a_in.tready), 32'(1));
        @(negedge clk);
        a_in.tvalid = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        int sc, prev_sc, gap, stall_idx, stall_lvl, found, en_count;

        a_in.tvalid  = 1'b0;
        a_in.tdata   = 8'h00;
        b_in.tvalid  = 1'b0;
        b_in.tdata   = 8'h00;
        a_out.tready = 1'b0;
        b_out.tready = 1'b0;
        stall_idx    = -1;
        stall_lvl    = -1;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_tready",  32'(a_in.tready), 32'(1));
        check("rst_tvalid",  32'(a_out.tvalid), 32'(0));
        check("rst_tdata",   32'(a_out.tdata), 32'(0));
        check("rst_tx_lvl",  32'(a_txl), 32'(0));
        check("rst_rx_lvl",  32'(a_rxl), 32'(0));
        check("rst_overrun", 32'(a_ovr), 32'(0));
        check("rst_perr",    32'(a_perr), 32'(0));
        check("rst_uart_tx", 32'(a_tx), 32'(1));
        check("rst_tx_en",   32'(dut_a.tx_en), 32'(0));

        // Single byte 0xA5: tx_en two cycles after acceptance, correct framing
        a_in.tdata  = 8'hA5;
        a_in.tvalid = 1'b1;
        @(negedge clk);
        a_in.tvalid = 1'b0;
        check("lat_tx_en_idle", 32'(dut_a.tx_en), 32'(0));
        check("lat_tx_lvl1",    32'(a_txl), 32'(1));
        @(negedge clk);
        check("lat_tx_en_start", 32'(dut_a.tx_en), 32'(1));
        capture(d, sc);
        check("tx_byte_a5", 32'(d), 32'(8'hA5));
        check("tx_lvl_after_a5", 32'(a_txl), 32'(0));
        repeat (10) @(negedge clk);

        // Burst of 20 bytes: 16 queued plus the one already popped into START
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    if (!a_in.tready && stall_idx < 0) begin
                        stall_idx = i;
                        stall_lvl = int'(a_txl);
                    end
                    push_byte(8'(i));
                end
            end
            begin
                prev_sc = -1;
                for (int k = 0; k < 20; k++) begin
                    capture(d, sc);
                    check($sformatf("tx_burst_byte%0d", k), 32'(d), 32'(k));
                    if (k > 0) begin
                        gap = sc - prev_sc;
                        check($sformatf("tx_burst_gap%0d", k), 32'(gap >= 41 && gap <= 43), 32'(1));
                    end
                    prev_sc = sc;
                end
            end
        join
        check("burst_stall_index", 32'(stall_idx), 32'(17));
        check("burst_stall_level", 32'(stall_lvl), 32'(16));
        check("burst_final_level", 32'(a_txl), 32'(0));
        repeat (10) @(negedge clk);

        // 17 serial bytes into a 16-deep RX FIFO with the sink stalled
        for (int i = 0; i < 17; i++) send_serial(1'b0, 8'(8'h40 + i), 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("rx_full_level",   32'(a_rxl), 32'(16));
        check("rx_overrun_set",  32'(a_ovr), 32'(1));
        check("rx_head_valid",   32'(a_out.tvalid), 32'(1));
        check("rx_head_data",    32'(a_out.tdata), 32'(8'h40));

        // clear_status coinciding with a fresh overrun leaves the flag set
        found = 0;
        fork
            send_serial(1'b0, 8'h51, 1'b0, 1'b0);
            begin
                for (int t = 0; t < 100 && found == 0; t++) begin
                    if (dut_a.rx_done) begin
                        a_clr = 1'b1;
                        found = 1;
                    end
                    @(negedge clk);
                end
                a_clr = 1'b0;
            end
        join
        check("clr_rx_done_seen",   32'(found), 32'(1));
        check("clr_same_cycle_ovr", 32'(a_ovr), 32'(1));
        check("clr_same_cycle_lvl", 32'(a_rxl), 32'(16));
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        check("clr_lone", 32'(a_ovr), 32'(0));

        // Drain: first 16 bytes in order, dropped bytes absent
        a_out.tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_valid%0d", i), 32'(a_out.tvalid), 32'(1));
            check($sformatf("drain_data%0d", i),  32'(a_out.tdata), 32'(8'h40 + i));
            @(negedge clk);
        end
        check("drain_empty_valid", 32'(a_out.tvalid), 32'(0));
        check("drain_empty_level", 32'(a_rxl), 32'(0));
        a_out.tready = 1'b0;

        // Parity instance: 0x3C with odd parity bit dropped, 0x3D with correct parity kept
        send_serial(1'b1, 8'h3C, 1'b1, 1'b1);
        send_serial(1'b1, 8'h3D, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("par_err_flag", 32'(b_perr), 32'(1));
        check("par_level",    32'(b_rxl), 32'(1));
        check("par_valid",    32'(b_out.tvalid), 32'(1));
        check("par_data",     32'(b_out.tdata), 32'(8'h3D));
        check("par_no_ovr",   32'(b_ovr), 32'(0));

        // Reset mid-transmit with bytes queued
        for (int i = 0; i < 5; i++) push_byte(8'(8'h60 + i));
        repeat (20) @(negedge clk);
        check("pre_rst_tx_lvl", 32'(a_txl), 32'(4));
        rst_n = 1'b0;
        #1;
        check("async_rst_tx_lvl",  32'(a_txl), 32'(0));
        check("async_rst_b_rxlvl", 32'(b_rxl), 32'(0));
        check("async_rst_uart_tx", 32'(a_tx), 32'(1));
        check("async_rst_tready",  32'(a_in.tready), 32'(1));
        check("async_rst_b_perr",  32'(b_perr), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        en_count = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (dut_a.tx_en) en_count++;
        end
        check("post_rst_no_tx_en", 32'(en_count), 32'(0));
        check("post_rst_line_idle", 32'(a_tx), 32'(1));
        push_byte(8'h5A);
        found = 0;
        for (int t = 0; t < 10 && found == 0; t++) begin
            if (dut_a.tx_en) found = 1;
            else @(negedge clk);
        end
        check("post_rst_new_push_tx_en", 32'(found), 32'(1));
        repeat (60) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
